// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: tracks in-flight destinations, picks operand bypass, raises load-use stall and branch flush.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
  parameter  int REG_AW   = 5,
  parameter  int STAGES   = 3,
  parameter  int LOAD_LAT = 1,
  parameter  int BR_STAGE = 1,
  localparam int FW       = $clog2(STAGES+1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wen_i,
  input  logic              id_load_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic [FW-1:0]     fwd_a_o,
  output logic [FW-1:0]     fwd_b_o,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic [STAGES-1:0] stage_valid_o
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              ld;
  } ent_t;

  ent_t              r_ent [STAGES];
  logic [STAGES-1:0] w_match_a, w_match_b;
  logic              w_haz;
  ent_t              w_new;

  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    w_haz     = 1'b0;
    fwd_a_o   = '0;
    fwd_b_o   = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_match_a[k] = r_ent[k].vld & r_ent[k].wen & (r_ent[k].rd == id_rs_i) &
                     (id_rs_i != '0) & id_rs_used_i;
      w_match_b[k] = r_ent[k].vld & r_ent[k].wen & (r_ent[k].rd == id_rt_i) &
                     (id_rt_i != '0) & id_rt_used_i;
    end
    // Walk oldest to youngest so the youngest producer lands last; a load not yet forwardable yields 0.
    for (int k = STAGES-1; k >= 0; k--) begin
      if (w_match_a[k]) fwd_a_o = (r_ent[k].ld && k < LOAD_LAT) ? '0 : FW'(k+1);
      if (w_match_b[k]) fwd_b_o = (r_ent[k].ld && k < LOAD_LAT) ? '0 : FW'(k+1);
      if (k < LOAD_LAT && r_ent[k].ld && (w_match_a[k] || w_match_b[k])) w_haz = 1'b1;
    end
    if (rst_i) begin
      fwd_a_o = '0;
      fwd_b_o = '0;
    end
  end

  assign flush_o  = branch_taken_i & ~rst_i;
  assign stall_o  = id_valid_i & w_haz & ~flush_o & ~rst_i;
  assign bubble_o = stall_o;

  always_comb begin
    w_new     = '0;
    w_new.vld = id_valid_i & ~stall_o & ~flush_o;
    w_new.rd  = id_rd_i;
    w_new.wen = id_wen_i;
    w_new.ld  = id_load_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) r_ent[k] <= '0;
    end else begin
      r_ent[0] <= w_new;
      // Entries younger than the branch are squashed on their way down.
      for (int k = 0; k < STAGES-1; k++) begin
        r_ent[k+1]     <= r_ent[k];
        if (flush_o && k < BR_STAGE) r_ent[k+1].vld <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) stage_valid_o[k] = r_ent[k].vld;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_o && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (default parameters) with a queue-based reference model.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 0, rsu = 0, rtu = 0, wen = 0, ld = 0, br = 0;
  logic [4:0] rs = 0, rt = 0, rd = 0;
  logic       stall, bubble, flush;
  logic [1:0] fa, fb;
  logic [2:0] sv;
  int         npass = 0, ntot = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(v), .id_rs_i(rs), .id_rt_i(rt),
    .id_rs_used_i(rsu), .id_rt_used_i(rtu), .id_rd_i(rd), .id_wen_i(wen),
    .id_load_i(ld), .branch_taken_i(br), .stall_o(stall), .bubble_o(bubble),
    .flush_o(flush), .fwd_a_o(fa), .fwd_b_o(fb), .stage_valid_o(sv));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: q[0] is the instruction that most recently left ID, q[2] the oldest in flight.
  typedef struct {bit v; int rd; bit w; bit ld;} rec_t;
  rec_t q[$];
  initial for (int i = 0; i < 3; i++) q.push_back('{0, 0, 0, 0});

  function automatic int m_fwd(int r, bit used);
    if (!used || r == 0) return 0;
    foreach (q[k]) if (q[k].v && q[k].w && q[k].rd == r) return (q[k].ld && k < 1) ? 0 : k + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    if (!v || br) return 0;
    return q[0].v && q[0].w && q[0].ld &&
           ((rsu && rs != 0 && q[0].rd == int'(rs)) || (rtu && rt != 0 && q[0].rd == int'(rt)));
  endfunction

  always @(posedge clk) begin
    rec_t n, o;
    if (rst) begin
      foreach (q[k]) q[k] = '{0, 0, 0, 0};
    end else begin
      n = '{v && !m_stall() && !br, int'(rd), wen, ld};
      if (br) begin o = q[0]; o.v = 0; q[0] = o; end
      q.push_front(n);
      void'(q.pop_back());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_stall", {31'd0, stall}, {31'd0, m_stall()});
      chk("m_bubble", {31'd0, bubble}, {31'd0, m_stall()});
      chk("m_flush", {31'd0, flush}, {31'd0, br});
      chk("m_valid", {29'd0, sv}, {29'd0, q[2].v, q[1].v, q[0].v});
      if (!m_stall()) begin
        chk("m_fwd_a", {30'd0, fa}, m_fwd(int'(rs), rsu));
        chk("m_fwd_b", {30'd0, fb}, m_fwd(int'(rt), rtu));
      end
    end
  end

  task automatic drv(input logic iv, input int irs, input int irt, input logic iru, input logic itu,
                     input int ird, input logic iw, input logic il, input logic ib);
    @(posedge clk); #2;
    v = iv; rs = 5'(irs); rt = 5'(irt); rsu = iru; rtu = itu;
    rd = 5'(ird); wen = iw; ld = il; br = ib;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 0; #1;
    chk("rst_valid", {29'd0, sv}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_fwd_a", {30'd0, fa}, 0);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);           // ADD r3
    chk("add_fwd_a_none", {30'd0, fa}, 0);
    drv(0, 3, 0, 1, 0, 0, 0, 0, 0);
    chk("fwd_ex", {30'd0, fa}, 1);
    drv(0, 3, 0, 1, 0, 0, 0, 0, 0);
    chk("fwd_mem", {30'd0, fa}, 2);
    drv(0, 3, 0, 1, 0, 0, 0, 0, 0);
    chk("fwd_wb", {30'd0, fa}, 3);
    drv(0, 3, 0, 1, 0, 0, 0, 0, 0);
    chk("fwd_retired", {30'd0, fa}, 0);
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0);           // LW r5
    drv(1, 0, 5, 0, 1, 0, 0, 0, 0);           // uses r5
    chk("lu_stall", {31'd0, stall}, 1);
    chk("lu_bubble", {31'd0, bubble}, 1);
    drv(1, 0, 5, 0, 1, 0, 0, 0, 0);
    chk("lu_valid", {29'd0, sv}, 3'b010);
    chk("lu_stall_end", {31'd0, stall}, 0);
    chk("lu_fwd_b", {30'd0, fb}, 2);
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);           // writer r7
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);           // writer r7 again
    drv(1, 7, 0, 1, 0, 9, 1, 1, 0);           // reads r7, LW r9
    chk("youngest", {30'd0, fa}, 1);
    drv(1, 0, 9, 1, 1, 0, 0, 0, 1);           // load-use on r9 plus taken branch
    chk("br_flush", {31'd0, flush}, 1);
    chk("br_stall", {31'd0, stall}, 0);
    chk("br_bubble", {31'd0, bubble}, 0);
    chk("br_valid_pre", {29'd0, sv}, 3'b111);
    chk("r0_src_fwd", {30'd0, fa}, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0);           // writer r0
    chk("br_valid_post", {29'd0, sv}, 3'b100);
    drv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("r0_never", {30'd0, fa}, 0);
    drv(1, 0, 0, 0, 0, 6, 1, 1, 0);           // LW r6
    drv(1, 6, 0, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", {31'd0, stall}, 1);
    @(posedge clk); #2 rst = 1; #1;
    @(posedge clk); #2 rst = 0; #1;
    chk("mid_rst_valid", {29'd0, sv}, 0);
    chk("mid_rst_stall", {31'd0, stall}, 0);
    chk("mid_rst_bubble", {31'd0, bubble}, 0);
    chk("mid_rst_fwd_a", {30'd0, fa}, 0);
    chk("mid_rst_flush", {31'd0, flush}, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline.
- Tracks destination-register scoreboard entries for every stage after ID in a shift structure.
- Outputs per-operand forwarding selects, load-use stall/bubble and branch flush control.
- Sits beside the ID stage:
  - Drives hold on PC and IF_ID.
  - Drives bubble into ID_EX.
  - Drives select lines of the operand muxes ahead of the ALU.

Parameters:
- REG_AW, 5, register-number width
- STAGES, 3, tracked stages after ID: entry 0 = EX, 1 = MEM, 2 = WB; range 2..7
- LOAD_LAT, 1, index of the first stage whose load data can be forwarded; a matching load in entries 0..LOAD_LAT-1 forces a stall
- BR_STAGE, 1, entry index where branches resolve; range 1..STAGES-1
- FW, clog2(STAGES+1), forwarding select width (derived)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i  in  REG_AW  source A register number
- id_rt_i  in  REG_AW  source B register number
- id_rs_used_i  in  1  source A is read
- id_rt_used_i  in  1  source B is read
- id_rd_i  in  REG_AW  destination register number
- id_wen_i  in  1  instruction writes id_rd_i
- id_load_i  in  1  instruction is a memory load
- branch_taken_i  in  1  branch in entry BR_STAGE resolved taken this cycle
- stall_o  out  1  hold PC and IF_ID (combinational)
- bubble_o  out  1  insert NOP into ID_EX (combinational)
- flush_o  out  1  invalidate IF_ID and younger stages (combinational)
- fwd_a_o  out  FW  0 = register file, k = entry k-1
- fwd_b_o  out  FW  same for source B
- stage_valid_o  out  STAGES  valid bit of each entry (registered)

Behaviour:
- Entry fields: valid, rd, wen, load.
- Reset (rst_i sampled high at an edge):
  - All entries cleared.
  - stage_valid_o=0; stall_o, bubble_o, flush_o, fwd_*=0 the same cycle.
  - Any in-flight stall is abandoned.
- Match(k, r) = entry[k].valid & entry[k].wen & entry[k].rd==r & r!=0. Register 0 never matches.
- Forwarding:
  - fwd_a_o = k+1 for the smallest k with Match(k, id_rs_i) & id_rs_used_i, else 0. fwd_b_o likewise with id_rt_i.
  - The youngest producer always wins.
  - Only k >= LOAD_LAT is reported when entry[k].load=1.
- Load-use hazard:
  - Condition: id_valid_i and, for some k < LOAD_LAT, Match on a used source with entry[k].load=1.
  - Response: stall_o=1, bubble_o=1.
  - Stall lasts until the load reaches entry LOAD_LAT (LOAD_LAT−k cycles).
- Flush:
  - flush_o = branch_taken_i. Flush overrides a hazard: stall_o=bubble_o=0 when flush_o=1.
  - At the edge, entries 0..BR_STAGE-1 are invalidated before the shift and the ID instruction is dropped.
  - entry[BR_STAGE] (the branch itself) and older entries survive.
- Clock edge, no reset:
  - entry[k+1] <= entry[k] for all k.
  - entry[0] <= ID fields if id_valid_i & !stall_o & !flush_o, else an invalid entry.
  - The oldest entry retires.
- Latency: fwd/stall/bubble/flush are combinational from inputs and current entries, with no registered delay. stage_valid_o reflects the state after the last edge.
- id_valid_i=0: no hazard raised, fwd_* still computed, entry[0] gets a bubble.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, two added outputs:
  - stall_cnt_o [31:0]: counts cycles with stall_o=1.
  - flush_cnt_o [31:0]: counts cycles with flush_o=1.
- Both counters reset to 0 by rst_i and saturate at 32'hFFFFFFFF with no wrap.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Defaults. ADD r3 issued, next cycle ID reads rs=r3 -> fwd_a_o=1. One cycle later (r3 in MEM) -> fwd_a_o=2. Then -> 3. Then -> 0.
- LW r5 then ID uses rt=r5 -> stall_o=bubble_o=1 for exactly 1 cycle, stage_valid_o=3'b010 after the edge. Next cycle fwd_b_o=2, stall_o=0.
- Writer r7 in entries 0 and 1 simultaneously, ID reads r7 -> fwd_a_o=1 (youngest wins). ID reads r0 with r0 writer in entry 0 -> fwd_a_o=0.
- branch_taken_i=1 with entries 0..2 valid -> flush_o=1. Next cycle stage_valid_o=3'b100, i.e. entry0 = dropped ID instruction (invalid), entry1 = flushed former entry 0 (invalid), entry2 = branch (valid). The former entry 2 retired at the edge. The same cycle with a load-use hazard -> stall_o=0.
- Assert rst_i mid-stall -> next cycle all outputs 0 and stage_valid_o=0. Stall not resumed.
- HAZARD_STATS_EN: 3 load-use stalls plus 2 flushes -> stall_cnt_o=3, flush_cnt_o=2. Reset -> both 0.
